jiancheng_seq: RTL and testbench

- Parametrised, clocked successor of the team's add/sub/mul arithmetic unit.
- Unsigned W-bit operands; sl selects add, subtract, multiply or divide.
- Add and subtract complete in 1 cycle. Multiply (shift-add) and divide (restoring) are iterative and take W+1 cycles.
- Used as the shared arithmetic engine behind the front-panel/control logic, with a start/done handshake.

---
 rtl/jiancheng_seq.sv | 140 ++++++++++++++
 tb/tb_jiancheng_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jiancheng_seq.sv
// rtl/jiancheng_seq.sv - clocked add/sub/mul/div engine with start/done handshake
// Optional restoring divider is built only when JIANCHENG_DIV_EN is defined.
module jiancheng_seq #(
    parameter int W  = 6,
    parameter int CW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     sl,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] c,
    output logic           err
);

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mc;
    logic [W-1:0]   r_b;
    logic           r_done;
    logic [2*W-1:0] r_c;
    logic           r_err;

    logic           w_accept;
    logic           w_iter;
    logic           w_last;
    logic [2*W-1:0] w_add;
    logic [2*W-1:0] w_sub;
    logic [2*W-1:0] w_mul_acc;
    logic [2*W-1:0] w_calc_acc;
    logic           w_calc_err;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_CALC) && (r_cnt == CW'(W - 1));
    assign w_add     = {{(W-1){1'b0}}, ({1'b0, a} + {1'b0, b})};
    assign w_sub     = {{W{1'b0}}, a} - {{W{1'b0}}, b};
    assign w_mul_acc = r_acc + (r_b[0] ? r_mc : '0);

`ifdef JIANCHENG_DIV_EN
    logic           r_is_div;
    logic [W:0]     w_shift;
    logic [W:0]     w_trial;
    logic [2*W-1:0] w_div_acc;

    // r_acc holds {remainder, dividend/quotient}; quotient bits shift in from the right
    assign w_iter     = sl[1];
    assign w_shift    = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_trial    = w_shift - {1'b0, r_b};
    assign w_div_acc  = w_trial[W] ? {w_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                   : {w_trial[W-1:0], r_acc[W-2:0], 1'b1};
    assign w_calc_acc = r_is_div ? w_div_acc : w_mul_acc;
    assign w_calc_err = r_is_div && (r_b == '0);
`else
    assign w_iter     = (sl == 2'b10);
    assign w_calc_acc = w_mul_acc;
    assign w_calc_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_iter) w_state_nxt = S_CALC;
            S_CALC:  if (w_last)             w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mc     <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
            r_c      <= '0;
            r_err    <= 1'b0;
`ifdef JIANCHENG_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt <= '0;
                r_b   <= b;
                r_mc  <= {{W{1'b0}}, a};
                if (w_iter) begin
`ifdef JIANCHENG_DIV_EN
                    r_is_div <= sl[0];
                    r_acc    <= sl[0] ? {{W{1'b0}}, a} : '0;
`else
                    r_acc    <= '0;
`endif
                end else begin
                    r_done <= 1'b1;
                    r_err  <= (sl == 2'b11);
                    case (sl)
                        2'b00:   r_c <= w_add;
                        2'b01:   r_c <= w_sub;
                        default: r_c <= '0;
                    endcase
                end
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CW'(1);
                r_acc <= w_calc_acc;
                r_mc  <= r_mc << 1;
`ifdef JIANCHENG_DIV_EN
                if (!r_is_div) r_b <= r_b >> 1;
`else
                r_b   <= r_b >> 1;
`endif
                if (w_last) begin
                    r_done <= 1'b1;
                    r_c    <= w_calc_acc;
                    r_err  <= w_calc_err;
                end
            end
        end
    end

    assign done = r_done;
    assign c    = r_c;
    assign err  = r_err;

endmodule

// File: tb/tb_jiancheng_seq.sv
// tb/tb_jiancheng_seq.sv - randomized self-checking bench for jiancheng_seq
module tb_jiancheng_seq;
    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [1:0]     sl;
    logic           busy;
    logic           done;
    logic [2*W-1:0] c;
    logic           err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jiancheng_seq #(.W(W), .CW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sl(sl),
        .busy(busy), .done(done), .c(c), .err(err)
    );

    // Arithmetic reference: result, error flag and edges from start edge to done
    function automatic void model(input int ai, input int bi, input logic [1:0] op,
                                  output logic [2*W-1:0] ec, output logic ee, output int lat);
        ee  = 1'b0;
        lat = 0;
        case (op)
            2'b00: ec = (2*W)'(ai + bi);
            2'b01: ec = (2*W)'(ai - bi);
            2'b10: begin ec = (2*W)'(ai * bi); lat = W; end
            default: begin
`ifdef JIANCHENG_DIV_EN
                lat = W;
                if (bi == 0) begin
                    ec = (2*W)'(ai * (1 << W) + (1 << W) - 1);
                    ee = 1'b1;
                end else begin
                    ec = (2*W)'((ai % bi) * (1 << W) + ai / bi);
                end
`else
                ec = '0;
                ee = 1'b1;
`endif
            end
        endcase
    endfunction

    task automatic do_op(input int ai, input int bi, input logic [1:0] op, input string tag);
        logic [2*W-1:0] ec;
        logic           ee;
        int             lat;
        int             cyc;
        bit             seen;
        model(ai, bi, op, ec, ee, lat);
        @(negedge clk);
        a = W'(ai); b = W'(bi); sl = op; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); sl = 2'($urandom);
        cyc = 0; seen = 0;
        while (!seen && cyc <= 3*W) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++; $display("FAIL %s busy cyc %0d got %b want 1", tag, cyc, busy);
                end
                cyc++;
            end
        end
        n_vec++;
        if (!seen || cyc != lat) begin
            n_err++; $display("FAIL %s latency got %0d (seen %0d) want %0d", tag, cyc, seen, lat);
        end
        if (seen) begin
            n_vec++;
            if (c !== ec) begin n_err++; $display("FAIL %s c got %h want %h", tag, c, ec); end
            n_vec++;
            if (err !== ee) begin n_err++; $display("FAIL %s err got %b want %b", tag, err, ee); end
            n_vec++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy at done got %b want 0", tag, busy); end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || c !== ec || err !== ee) begin
                n_err++; $display("FAIL %s hold done %b c %h err %b want 0 %h %b", tag, done, c, err, ec, ee);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sl = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, done, err} !== 3'b000 || c !== '0) begin
            n_err++; $display("FAIL reset busy %b done %b err %b c %h want 0 0 0 0", busy, done, err, c);
        end
        rst = 1'b0;
    endtask

    task automatic test_plan();
        do_op(4, 10, 2'b11, "div_4_10");
        do_op(63, 63, 2'b00, "add_63_63");
        do_op(63, 63, 2'b10, "mul_63_63");
        do_op(4, 10, 2'b01, "sub_4_10");
        do_op(9, 0, 2'b11, "div_by_zero");
        do_op(0, 63, 2'b01, "sub_0_63");
        do_op(63, 1, 2'b11, "div_63_1");
    endtask

    task automatic test_busy_ignore(input int ai, input int bi, input logic [1:0] op, input string tag);
        logic [2*W-1:0] ec;
        logic           ee;
        int             lat;
        int             nd;
        model(ai, bi, op, ec, ee, lat);
        @(negedge clk);
        a = W'(ai); b = W'(bi); sl = op; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        for (int i = 0; i < 3*W; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (i == 2) begin
                start = 1'b1; sl = 2'b00; a = W'(1); b = W'(1);
            end else begin
                start = 1'b0;
            end
        end
        n_vec++;
        if (nd != 1) begin n_err++; $display("FAIL %s done count got %0d want 1", tag, nd); end
        n_vec++;
        if (c !== ec || err !== ee) begin
            n_err++; $display("FAIL %s c %h err %b want %h %b", tag, c, err, ec, ee);
        end
    endtask

    task automatic test_abort();
        int nd;
        do_op(20, 30, 2'b00, "pre_abort_add");
        @(negedge clk);
        a = W'(5); b = W'(7); sl = 2'b10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({busy, done, err} !== 3'b000 || c !== '0) begin
            n_err++; $display("FAIL abort busy %b done %b err %b c %h want 0 0 0 0", busy, done, err, c);
        end
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        n_vec++;
        if (nd != 0) begin n_err++; $display("FAIL abort activity got %0d want 0", nd); end
        do_op(5, 7, 2'b10, "mul_after_abort");
    endtask

    task automatic test_back_to_back();
        int             nd;
        int             dcyc;
        logic [2*W-1:0] cap;
        @(negedge clk);
        a = W'(1); b = W'(2); sl = 2'b00; start = 1'b1;
        @(posedge clk);
        #1 sl = 2'b10; a = W'(3); b = W'(3);
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || c !== (2*W)'(3)) begin
            n_err++; $display("FAIL b2b first done %b c %h want 1 003", done, c);
        end
        @(posedge clk);
        #1 start = 1'b0;
        nd = 1; dcyc = -1; cap = '0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (dcyc < 0) begin dcyc = i; cap = c; end
            end
        end
        n_vec++;
        if (nd != 2) begin n_err++; $display("FAIL b2b done count got %0d want 2", nd); end
        n_vec++;
        if (dcyc != W || cap !== (2*W)'(9)) begin
            n_err++; $display("FAIL b2b second at %0d c %h want %0d 009", dcyc, cap, W);
        end
    endtask

    task automatic test_random();
        int ai;
        int bi;
        logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            ai = int'($urandom_range(0, (1 << W) - 1));
            bi = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
            op = 2'($urandom);
            do_op(ai, bi, op, "random");
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_busy_ignore(5, 7, 2'b10, "ignore_mul");
`ifdef JIANCHENG_DIV_EN
        test_busy_ignore(9, 0, 2'b11, "ignore_div");
`endif
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
